avalon_mm_master: RTL and testbench
===================================

Name: avalon_mm_master

Overview:
- Avalon-MM initiator; the bus-driving counterpart of avalon_mm_slave.
- Converts single-beat read/write commands from a valid/ready command port into Avalon-MM transfers and honours avm_waitrequest.
- Returns completion status and read data on a valid/ready response port.
- Sits between an internal controller (e.g. a register-sequence engine) and any Avalon-MM slave; one outstanding transfer at a time, no bursts, no readdatavalid.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (multiple of 8)
TIMEOUT_CYCLES, 256, max waitrequest-high cycles per transfer (used only with AVM_TIMEOUT_EN; must be >= 2)

Ports:
clk  input  1  clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command
cmd_write  input  1  1 = write, 0 = read
cmd_address  input  ADDR_W  target address, passed through unmodified
cmd_writedata  input  DATA_W  write data
cmd_byteenable  input  DATA_W/8  byte lanes for writes
rsp_valid  output  1  response present
rsp_ready  input  1  response consumer ready
rsp_write  output  1  echo of the command type
rsp_readdata  output  DATA_W  captured read data (0 for writes)
rsp_error  output  1  transfer aborted by timeout
avm_address  output  ADDR_W  bus address
avm_read  output  1  bus read strobe
avm_write  output  1  bus write strobe
avm_chipselect  output  1  bus chipselect
avm_writedata  output  DATA_W  bus write data
avm_byteenable  output  DATA_W/8  bus byte enables
avm_readdata  input  DATA_W  bus read data
avm_waitrequest  input  1  slave stall

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous and active-low on reset_n. All outputs are registered.
- Reset values: every output is 0; FSM state is IDLE. cmd_ready rises on the first clk edge after reset_n deasserts.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - cmd_ready = 1.
  - A command is accepted on an edge where cmd_valid and cmd_ready are both 1; the state goes to ACCESS.
  - Bus outputs are driven from the registered command on that same edge.
  - In ACCESS, cmd_ready = 0.
- ACCESS:
  - avm_chipselect = 1; avm_read or avm_write = 1 per cmd_write.
  - avm_address, avm_writedata and avm_byteenable stay stable while avm_waitrequest = 1.
  - Reads drive avm_writedata = 0 and avm_byteenable = all ones.
  - Completion: the edge where avm_waitrequest = 0. On that edge:
    - reads capture avm_readdata into rsp_readdata;
    - avm_read, avm_write, avm_chipselect, avm_address, avm_writedata and avm_byteenable return to 0;
    - rsp_valid = 1, rsp_write = command type, rsp_error = 0;
    - the state goes to RESP.
- RESP:
  - rsp_* held stable until an edge with rsp_ready = 1; then rsp_valid = 0, state IDLE, cmd_ready = 1.
  - If rsp_ready is already 1 on entry, the response lasts exactly one cycle.
- Latency: accept at edge N, strobe visible after N. Earliest completion is edge N+1, with rsp_valid after N+1. Minimum 3 cycles from one accept to the next.
- Strobes are never asserted outside ACCESS. A zero-wait transfer holds its strobe for exactly one cycle.
- cmd_* inputs are ignored when not accepted. rsp_ready is ignored outside RESP.
- Reset mid-operation: strobes and rsp_valid drop immediately (asynchronously). The pending command is discarded and no response is issued.

Optional Feature:
- Macro AVM_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ACCESS and increments on each ACCESS edge with avm_waitrequest = 1.
  - If avm_waitrequest = 1 on an edge where the count equals TIMEOUT_CYCLES-1, the transfer aborts: strobes drop, rsp_valid = 1, rsp_error = 1, rsp_readdata = 0, state RESP.
  - Normal completion and the limit cannot coincide, because completion requires avm_waitrequest = 0.
- Undefined: no counter; the block waits on avm_waitrequest indefinitely; rsp_error is tied to 0.

Decomposition:
- Package avalon_mm_pkg holds:
  - the FSM state enum (IDLE/ACCESS/RESP);
  - default ADDR_W/DATA_W constants;
  - a response struct (write, readdata, error).
- One sub-module, avm_timeout_counter (clear, enable, limit-reached), instantiated only under AVM_TIMEOUT_EN.

Test Plan:
- Zero-wait write: addr 0x10, data 0xDEADBEEF, byteenable 0xF, waitrequest 0 -> avm_write high exactly 1 cycle with those values; rsp_valid 2 cycles after accept; rsp_write = 1; rsp_error = 0.
- Stalled read: addr 0x14, waitrequest high 3 cycles, then readdata 0x12345678 -> avm_read high 4 cycles with address stable; rsp_readdata = 0x12345678.
- Response backpressure: rsp_ready low 5 cycles after completion -> rsp_valid and rsp_readdata held; cmd_ready = 0; a queued command is not accepted until the cycle after rsp_ready = 1.
- Reset in ACCESS: reset_n low while avm_read is high under waitrequest -> strobes and chipselect 0 immediately, no rsp_valid; cmd_ready = 1 one edge after release.
- Timeout (AVM_TIMEOUT_EN, TIMEOUT_CYCLES = 8): waitrequest stuck high -> avm_read high exactly 8 cycles; rsp_error = 1; rsp_readdata = 0. Without the macro, avm_read stays high for 100+ cycles.
- Back-to-back: cmd_valid held with write 0x20 then read 0x20, slave echoes -> second command accepted in the first cycle cmd_ready returns; read response returns the written value.

Source files
------------

// File: rtl/avalon_mm_pkg.sv
// Shared definitions for the Avalon-MM initiator: FSM state encoding,
// default bus widths and the response record handed back to the controller.
package avalon_mm_pkg;

    // Default widths used when the top-level parameters are not overridden.
    localparam int unsigned AVM_ADDR_W_DEFAULT = 32;
    localparam int unsigned AVM_DATA_W_DEFAULT = 32;

    // IDLE waits for a command, ACCESS drives the bus until waitrequest
    // drops (or the optional timeout fires), RESP holds the result until
    // the consumer takes it.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } avm_state_e;

    // One completed transfer as seen on the response port.
    typedef struct packed {
        logic                          write;
        logic [AVM_DATA_W_DEFAULT-1:0] readdata;
        logic                          error;
    } avm_rsp_t;

endpackage

// File: rtl/avm_timeout_counter.sv
// Counts waitrequest-stalled cycles of one Avalon-MM transfer and flags the
// cycle on which the stall budget is exhausted. Only instantiated when the
// initiator is built with AVM_TIMEOUT_EN.
module avm_timeout_counter
    import avalon_mm_pkg::*;
#(
    parameter int unsigned LIMIT = 256
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_limit_reached
);

    // Wide enough to hold LIMIT-1; a limit of 2 still needs one bit.
    localparam int unsigned CntW = (LIMIT > 2) ? $clog2(LIMIT) : 1;

    logic [CntW-1:0] r_count;

    // Clear has priority so a new transfer always starts from zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_limit_reached = (r_count == CntW'(LIMIT - 1));

endmodule

// File: rtl/avalon_mm_master.sv
// Avalon-MM initiator: turns single-beat read/write commands from a
// valid/ready command port into Avalon-MM transfers, honours waitrequest,
// and returns status plus read data on a valid/ready response port.
// One transfer outstanding at a time, no bursts, no readdatavalid.
// Build option: define AVM_TIMEOUT_EN to abort transfers whose waitrequest
// stays high for TIMEOUT_CYCLES cycles (reported via rsp_error).
module avalon_mm_master
    import avalon_mm_pkg::*;
#(
    parameter int unsigned ADDR_W         = AVM_ADDR_W_DEFAULT,
    parameter int unsigned DATA_W         = AVM_DATA_W_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                clk,
    input  logic                reset_n,

    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_address,
    input  logic [DATA_W-1:0]   cmd_writedata,
    input  logic [DATA_W/8-1:0] cmd_byteenable,

    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_write,
    output logic [DATA_W-1:0]   rsp_readdata,
    output logic                rsp_error,

    output logic [ADDR_W-1:0]   avm_address,
    output logic                avm_read,
    output logic                avm_write,
    output logic                avm_chipselect,
    output logic [DATA_W-1:0]   avm_writedata,
    output logic [DATA_W/8-1:0] avm_byteenable,
    input  logic [DATA_W-1:0]   avm_readdata,
    input  logic                avm_waitrequest
);

    localparam int unsigned BeW = DATA_W / 8;

    // A timeout budget below two cycles cannot be honoured by the counter;
    // such a configuration elaborates this empty marker block.
    if (TIMEOUT_CYCLES < 2) begin : g_timeout_cfg_invalid
    end

    avm_state_e r_state;
    avm_state_e w_next_state;

    logic              r_cmd_ready;
    logic              r_rsp_valid;
    logic              r_rsp_write;
    logic [DATA_W-1:0] r_rsp_readdata;
    logic              r_rsp_error;
    logic [ADDR_W-1:0] r_avm_address;
    logic              r_avm_read;
    logic              r_avm_write;
    logic              r_avm_chipselect;
    logic [DATA_W-1:0] r_avm_writedata;
    logic [BeW-1:0]    r_avm_byteenable;

    logic              w_nxt_cmd_ready;
    logic              w_nxt_rsp_valid;
    logic              w_nxt_rsp_write;
    logic [DATA_W-1:0] w_nxt_rsp_readdata;
    logic              w_nxt_rsp_error;
    logic [ADDR_W-1:0] w_nxt_avm_address;
    logic              w_nxt_avm_read;
    logic              w_nxt_avm_write;
    logic              w_nxt_avm_chipselect;
    logic [DATA_W-1:0] w_nxt_avm_writedata;
    logic [BeW-1:0]    w_nxt_avm_byteenable;

    logic              w_accept;
    logic              w_timeout;

    // Handshake only counts once cmd_ready is actually showing, so the
    // first edge after reset never accepts a command.
    assign w_accept = (r_state == IDLE) && cmd_valid && r_cmd_ready;

`ifdef AVM_TIMEOUT_EN
    logic w_limit_reached;
    logic w_count_enable;

    assign w_count_enable = (r_state == ACCESS) && avm_waitrequest;

    avm_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_counter (
        .clk             (clk),
        .reset_n         (reset_n),
        .i_clear         (w_accept),
        .i_enable        (w_count_enable),
        .o_limit_reached (w_limit_reached)
    );

    assign w_timeout = w_limit_reached && avm_waitrequest;
`else
    assign w_timeout = 1'b0;
`endif

    // State register; reset drops straight back to IDLE discarding any
    // pending command.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and next-output logic; every output is computed here and
    // registered below so nothing on the ports is combinational.
    always_comb begin
        w_next_state         = r_state;
        w_nxt_cmd_ready      = r_cmd_ready;
        w_nxt_rsp_valid      = r_rsp_valid;
        w_nxt_rsp_write      = r_rsp_write;
        w_nxt_rsp_readdata   = r_rsp_readdata;
        w_nxt_rsp_error      = r_rsp_error;
        w_nxt_avm_address    = r_avm_address;
        w_nxt_avm_read       = r_avm_read;
        w_nxt_avm_write      = r_avm_write;
        w_nxt_avm_chipselect = r_avm_chipselect;
        w_nxt_avm_writedata  = r_avm_writedata;
        w_nxt_avm_byteenable = r_avm_byteenable;

        case (r_state)
            IDLE: begin
                w_nxt_cmd_ready = 1'b1;
                if (w_accept) begin
                    w_next_state         = ACCESS;
                    w_nxt_cmd_ready      = 1'b0;
                    w_nxt_avm_chipselect = 1'b1;
                    w_nxt_avm_read       = !cmd_write;
                    w_nxt_avm_write      = cmd_write;
                    w_nxt_avm_address    = cmd_address;
                    w_nxt_avm_writedata  = cmd_write ? cmd_writedata : '0;
                    w_nxt_avm_byteenable = cmd_write ? cmd_byteenable : '1;
                end
            end

            ACCESS: begin
                if (!avm_waitrequest || w_timeout) begin
                    w_next_state         = RESP;
                    w_nxt_rsp_valid      = 1'b1;
                    w_nxt_rsp_write      = r_avm_write;
                    w_nxt_rsp_error      = w_timeout;
                    w_nxt_rsp_readdata   = (r_avm_read && !w_timeout) ? avm_readdata : '0;
                    w_nxt_avm_chipselect = 1'b0;
                    w_nxt_avm_read       = 1'b0;
                    w_nxt_avm_write      = 1'b0;
                    w_nxt_avm_address    = '0;
                    w_nxt_avm_writedata  = '0;
                    w_nxt_avm_byteenable = '0;
                end
            end

            RESP: begin
                if (rsp_ready) begin
                    w_next_state    = IDLE;
                    w_nxt_rsp_valid = 1'b0;
                    w_nxt_cmd_ready = 1'b1;
                end
            end

            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Output registers; asynchronous reset makes strobes and rsp_valid
    // drop the moment reset_n falls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cmd_ready      <= 1'b0;
            r_rsp_valid      <= 1'b0;
            r_rsp_write      <= 1'b0;
            r_rsp_readdata   <= '0;
            r_rsp_error      <= 1'b0;
            r_avm_address    <= '0;
            r_avm_read       <= 1'b0;
            r_avm_write      <= 1'b0;
            r_avm_chipselect <= 1'b0;
            r_avm_writedata  <= '0;
            r_avm_byteenable <= '0;
        end else begin
            r_cmd_ready      <= w_nxt_cmd_ready;
            r_rsp_valid      <= w_nxt_rsp_valid;
            r_rsp_write      <= w_nxt_rsp_write;
            r_rsp_readdata   <= w_nxt_rsp_readdata;
            r_rsp_error      <= w_nxt_rsp_error;
            r_avm_address    <= w_nxt_avm_address;
            r_avm_read       <= w_nxt_avm_read;
            r_avm_write      <= w_nxt_avm_write;
            r_avm_chipselect <= w_nxt_avm_chipselect;
            r_avm_writedata  <= w_nxt_avm_writedata;
            r_avm_byteenable <= w_nxt_avm_byteenable;
        end
    end

    assign cmd_ready      = r_cmd_ready;
    assign rsp_valid      = r_rsp_valid;
    assign rsp_write      = r_rsp_write;
    assign rsp_readdata   = r_rsp_readdata;
    assign rsp_error      = r_rsp_error;
    assign avm_address    = r_avm_address;
    assign avm_read       = r_avm_read;
    assign avm_write      = r_avm_write;
    assign avm_chipselect = r_avm_chipselect;
    assign avm_writedata  = r_avm_writedata;
    assign avm_byteenable = r_avm_byteenable;

endmodule

// File: tb/tb_avalon_mm_master.sv
// Directed testbench for avalon_mm_master: zero-wait write, stalled read
// with response backpressure, back-to-back write/read through an echoing
// slave, reset during ACCESS, and stall timeout (AVM_TIMEOUT_EN) or
// indefinite waiting (default build).
module tb_avalon_mm_master;
    import avalon_mm_pkg::*;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned TIMEOUT_CYCLES = 8;

    logic              clk;
    logic              reset_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_address;
    logic [DATA_W-1:0] cmd_writedata;
    logic [3:0]        cmd_byteenable;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_write;
    logic [DATA_W-1:0] rsp_readdata;
    logic              rsp_error;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_write;
    logic              avm_chipselect;
    logic [DATA_W-1:0] avm_writedata;
    logic [3:0]        avm_byteenable;
    logic [DATA_W-1:0] avm_readdata;
    logic              avm_waitrequest;

    logic              echoMode;
    logic [DATA_W-1:0] echoData;
    logic [DATA_W-1:0] manualReadData;

    int checkCount;
    int errorCount;
    int highCycles;
    avm_rsp_t expRsp;

    avalon_mm_master #(
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_write       (cmd_write),
        .cmd_address     (cmd_address),
        .cmd_writedata   (cmd_writedata),
        .cmd_byteenable  (cmd_byteenable),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_write       (rsp_write),
        .rsp_readdata    (rsp_readdata),
        .rsp_error       (rsp_error),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_write       (avm_write),
        .avm_chipselect  (avm_chipselect),
        .avm_writedata   (avm_writedata),
        .avm_byteenable  (avm_byteenable),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Echo slave: remembers the last accepted write so a later read returns it
    always @(posedge clk) begin
        if (avm_chipselect && avm_write && !avm_waitrequest) begin
            echoData <= avm_writedata;
        end
    end

    assign avm_readdata = echoMode ? echoData : manualReadData;

    // Global time bound so the bench can never hang
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic write,
                                 input logic [ADDR_W-1:0] addr,
                                 input logic [DATA_W-1:0] wdata,
                                 input logic [3:0] be);
        cmd_valid      = valid;
        cmd_write      = write;
        cmd_address    = addr;
        cmd_writedata  = wdata;
        cmd_byteenable = be;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    initial begin
        checkCount      = 0;
        errorCount      = 0;
        echoMode        = 1'b0;
        echoData        = '0;
        manualReadData  = '0;
        reset_n         = 1'b0;
        rsp_ready       = 1'b1;
        avm_waitrequest = 1'b0;
        applyStimulus(1'b0, 1'b0, '0, '0, '0);

        // Reset state
        tick();
        tick();
        checkOutput("rst_cmd_ready", cmd_ready, 0);
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_strobes", {avm_read, avm_write, avm_chipselect}, 0);
        checkOutput("rst_address", avm_address, 0);
        reset_n = 1'b1;
        tick();
        checkOutput("post_rst_cmd_ready", cmd_ready, 1);

        // Zero-wait write
        $display("[TB] zero-wait write");
        applyStimulus(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        checkOutput("zw_avm_write", avm_write, 1);
        checkOutput("zw_avm_read", avm_read, 0);
        checkOutput("zw_chipselect", avm_chipselect, 1);
        checkOutput("zw_address", avm_address, 32'h10);
        checkOutput("zw_writedata", avm_writedata, 32'hDEADBEEF);
        checkOutput("zw_byteenable", avm_byteenable, 4'hF);
        checkOutput("zw_cmd_ready_busy", cmd_ready, 0);
        checkOutput("zw_rsp_not_yet", rsp_valid, 0);
        tick();
        expRsp = '{write: 1'b1, readdata: 32'h0, error: 1'b0};
        checkOutput("zw_write_dropped", {avm_write, avm_chipselect}, 0);
        checkOutput("zw_address_cleared", avm_address, 0);
        checkOutput("zw_rsp_valid", rsp_valid, 1);
        checkOutput("zw_rsp_write", rsp_write, expRsp.write);
        checkOutput("zw_rsp_readdata", rsp_readdata, expRsp.readdata);
        checkOutput("zw_rsp_error", rsp_error, expRsp.error);
        tick();
        checkOutput("zw_rsp_released", rsp_valid, 0);
        checkOutput("zw_cmd_ready_back", cmd_ready, 1);

        // Stalled read with 3 waitrequest cycles, then response backpressure
        $display("[TB] stalled read with backpressure");
        avm_waitrequest = 1'b1;
        manualReadData  = 32'hBAD0BAD0;
        applyStimulus(1'b1, 1'b0, 32'h14, 32'hAAAA5555, 4'h3);
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        checkOutput("sr_avm_read", avm_read, 1);
        checkOutput("sr_writedata_zero", avm_writedata, 0);
        checkOutput("sr_byteenable_ones", avm_byteenable, 4'hF);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("sr_read_held", avm_read, 1);
            checkOutput("sr_address_stable", avm_address, 32'h14);
        end
        avm_waitrequest = 1'b0;
        manualReadData  = 32'h12345678;
        rsp_ready       = 1'b0;
        tick();
        expRsp = '{write: 1'b0, readdata: 32'h12345678, error: 1'b0};
        checkOutput("sr_read_dropped", avm_read, 0);
        checkOutput("sr_rsp_valid", rsp_valid, 1);
        checkOutput("sr_rsp_write", rsp_write, expRsp.write);
        checkOutput("sr_rsp_readdata", rsp_readdata, expRsp.readdata);
        manualReadData = 32'hFFFF0000;
        echoMode = 1'b1;
        applyStimulus(1'b1, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("bp_rsp_valid_held", rsp_valid, 1);
            checkOutput("bp_readdata_held", rsp_readdata, 32'h12345678);
            checkOutput("bp_cmd_ready_low", cmd_ready, 0);
            checkOutput("bp_no_accept", avm_write, 0);
        end
        rsp_ready = 1'b1;
        tick();
        checkOutput("bp_rsp_released", rsp_valid, 0);
        checkOutput("bp_cmd_ready_back", cmd_ready, 1);
        checkOutput("bp_not_accepted_yet", avm_write, 0);

        // Back-to-back write then read through the echo slave
        $display("[TB] back-to-back write/read");
        tick();
        checkOutput("b2b_write_accepted", avm_write, 1);
        checkOutput("b2b_write_address", avm_address, 32'h20);
        applyStimulus(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
        tick();
        checkOutput("b2b_write_rsp", {rsp_valid, rsp_write}, 2'b11);
        checkOutput("b2b_cmd_ready_low", cmd_ready, 0);
        tick();
        checkOutput("b2b_cmd_ready_back", cmd_ready, 1);
        checkOutput("b2b_read_not_yet", avm_read, 0);
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        checkOutput("b2b_read_accepted", avm_read, 1);
        checkOutput("b2b_read_address", avm_address, 32'h20);
        tick();
        checkOutput("b2b_read_rsp_valid", rsp_valid, 1);
        checkOutput("b2b_read_echo", rsp_readdata, 32'hCAFEF00D);
        tick();
        echoMode = 1'b0;

        // Reset while a stalled read is on the bus
        $display("[TB] reset during access");
        avm_waitrequest = 1'b1;
        applyStimulus(1'b1, 1'b0, 32'h30, '0, 4'hF);
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        checkOutput("ra_read_before", avm_read, 1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("ra_strobes_async", {avm_read, avm_write, avm_chipselect}, 0);
        checkOutput("ra_rsp_valid_async", rsp_valid, 0);
        checkOutput("ra_cmd_ready_async", cmd_ready, 0);
        avm_waitrequest = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        checkOutput("ra_cmd_ready_release", cmd_ready, 1);
        checkOutput("ra_no_response", rsp_valid, 0);
        tick();
        checkOutput("ra_still_no_response", rsp_valid, 0);

        // Waitrequest stuck high
        $display("[TB] stuck waitrequest");
        avm_waitrequest = 1'b1;
        manualReadData  = 32'h00000099;
        applyStimulus(1'b1, 1'b0, 32'h40, '0, 4'hF);
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        highCycles = 0;
        for (int i = 0; i < 120 && avm_read; i++) begin
            highCycles++;
            tick();
        end
`ifdef AVM_TIMEOUT_EN
        checkOutput("to_strobe_cycles", highCycles, TIMEOUT_CYCLES);
        checkOutput("to_rsp_valid", rsp_valid, 1);
        checkOutput("to_rsp_error", rsp_error, 1);
        checkOutput("to_rsp_readdata", rsp_readdata, 0);
        checkOutput("to_chipselect_off", avm_chipselect, 0);
`else
        checkOutput("nt_strobe_cycles", highCycles, 120);
        checkOutput("nt_read_still_high", avm_read, 1);
        checkOutput("nt_no_response", rsp_valid, 0);
        avm_waitrequest = 1'b0;
        tick();
        checkOutput("nt_rsp_valid", rsp_valid, 1);
        checkOutput("nt_rsp_error", rsp_error, 0);
        checkOutput("nt_rsp_readdata", rsp_readdata, 32'h00000099);
`endif
        avm_waitrequest = 1'b0;
        tick();
        checkOutput("end_rsp_released", rsp_valid, 0);
        checkOutput("end_cmd_ready", cmd_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
